// File: rtl/lvt_pkg.sv
// Shared definitions for the live-value-table multi-port RAM: sizing helpers and FSM states.
package lvt_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // LVT entry width: wide enough to name any write port, never zero.
  function automatic int lw(input int nw);
    return (clog2(nw) < 1) ? 1 : clog2(nw);
  endfunction

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/lvt_mpram_if.sv
// Write/read port bundle of lvt_mpram; master drives accesses, slave is the RAM.
interface lvt_mpram_if #(
  parameter int DW = 32,
  parameter int AW = 7,
  parameter int NW = 2,
  parameter int NR = 1
);
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic             ready;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, ready
  );
endinterface

// File: rtl/lvt_bank.sv
// 1-write/1-read synchronous RAM; read-before-write, 1-cycle read, output holds when re_i=0.
module lvt_bank #(
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/lvt_mpram.sv
// NW-write/NR-read RAM: one bank per write port (replicated per read port), LVT steers reads.
// Optional same-cycle write-to-read forwarding when LVT_BYPASS_EN is defined.
module lvt_mpram
  import lvt_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  parameter int NW    = 2,
  parameter int NR    = 1
) (
  input logic        clk,
  input logic        rst,
  lvt_mpram_if.slave bus
);
  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int LW = lw(NW);

  state_e        state_q;
  logic [AW-1:0] clr_addr_q;
  logic          ready_q;
  logic          run, clearing;

  logic [LW-1:0] lvt_q [DEPTH];
  logic [AW-1:0] wa [NW];
  logic [DW-1:0] wd [NW];
  logic [AW-1:0] ra [NR];
  logic [NW-1:0] wr_ok;
  logic [NR-1:0] rd_ok, rd_in;

  logic [NW-1:0] bank_we;
  logic [AW-1:0] bank_wa [NW];
  logic [DW-1:0] bank_wd [NW];
  logic [DW-1:0] bank_rd [NW][NR];

  logic [NR-1:0]    valid_q, oor_q;
  logic [LW-1:0]    sel_q [NR];
  logic [NR*DW-1:0] rd_data_d;

  assign run      = (state_q == ST_RUN) && !rst;
  assign clearing = (state_q == ST_CLEAR) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_addr_q == AW'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  for (genvar p = 0; p < NW; p++) begin : g_wr
    assign wa[p]      = bus.wr_addr[p*AW +: AW];
    assign wd[p]      = bus.wr_data[p*DW +: DW];
    assign wr_ok[p]   = run && bus.wr_en[p] && (32'(wa[p]) < DEPTH);
    assign bank_we[p] = clearing || wr_ok[p];
    assign bank_wa[p] = clearing ? clr_addr_q : wa[p];
    assign bank_wd[p] = clearing ? '0 : wd[p];
    for (genvar r = 0; r < NR; r++) begin : g_rep
      lvt_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bank_we[p]),
        .waddr_i (bank_wa[p]),
        .wdata_i (bank_wd[p]),
        .re_i    (rd_ok[r]),
        .raddr_i (ra[r]),
        .rdata_o (bank_rd[p][r])
      );
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    assign ra[r]    = bus.rd_addr[r*AW +: AW];
    assign rd_ok[r] = run && bus.rd_en[r];
    assign rd_in[r] = 32'(ra[r]) < DEPTH;
  end

  // Ascending loop: the highest enabled port's update lands last and wins.
  always_ff @(posedge clk) begin
    if (clearing) begin
      lvt_q[clr_addr_q] <= '0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (wr_ok[p]) lvt_q[wa[p]] <= LW'(p);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      oor_q   <= '0;
      for (int r = 0; r < NR; r++) sel_q[r] <= '0;
    end else begin
      valid_q <= rd_ok;
      for (int r = 0; r < NR; r++) begin
        if (rd_ok[r]) begin
          sel_q[r] <= lvt_q[ra[r]];
          oor_q[r] <= !rd_in[r];
        end
      end
    end
  end

`ifdef LVT_BYPASS_EN
  logic [NR-1:0] byp_d, byp_q;
  logic [DW-1:0] byp_dat_d [NR];
  logic [DW-1:0] byp_dat_q [NR];

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      byp_d[r]     = 1'b0;
      byp_dat_d[r] = '0;
      for (int p = 0; p < NW; p++) begin
        if (wr_ok[p] && (wa[p] == ra[r])) begin
          byp_d[r]     = 1'b1;
          byp_dat_d[r] = wd[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q <= '0;
      for (int r = 0; r < NR; r++) byp_dat_q[r] <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (rd_ok[r]) begin
          byp_q[r]     <= byp_d[r];
          byp_dat_q[r] <= byp_dat_d[r];
        end
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int r = 0; r < NR; r++) begin
      if (oor_q[r])      rd_data_d[r*DW +: DW] = '0;
      else if (byp_q[r]) rd_data_d[r*DW +: DW] = byp_dat_q[r];
      else               rd_data_d[r*DW +: DW] = bank_rd[sel_q[r]][r];
    end
  end
`else
  always_comb begin
    rd_data_d = '0;
    for (int r = 0; r < NR; r++) begin
      if (!oor_q[r]) rd_data_d[r*DW +: DW] = bank_rd[sel_q[r]][r];
    end
  end
`endif

  assign bus.rd_data  = rd_data_d;
  assign bus.rd_valid = valid_q;
  assign bus.ready    = ready_q;
endmodule

// File: tb/tb_lvt_mpram.sv
// Bench for lvt_mpram (3 write / 2 read ports): directed cases plus random traffic vs. an array model.
module tb_lvt_mpram;
  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int NW    = 3;
  localparam int NR    = 2;
  localparam int AW    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  lvt_mpram_if #(.DW(DW), .AW(AW), .NW(NW), .NR(NR)) bus ();

  lvt_mpram #(.DW(DW), .DEPTH(DEPTH), .NW(NW), .NR(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain word array plus per-port expected outputs.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_dat [NR];
  logic [NR-1:0] exp_vld;

  logic [NW-1:0] s_we;
  int            s_wa [NW];
  logic [DW-1:0] s_wd [NW];
  logic [NR-1:0] s_re;
  int            s_ra [NR];

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    for (int r = 0; r < NR; r++) exp_dat[r] = '0;
    exp_vld = '0;
    s_we = '0;
    s_re = '0;
    for (int p = 0; p < NW; p++) begin s_wa[p] = 0; s_wd[p] = '0; end
    for (int r = 0; r < NR; r++) s_ra[r] = 0;
  endtask

  // Apply one cycle of stimulus to both the DUT and the model; returns #1 after the edge.
  task automatic tick();
    for (int p = 0; p < NW; p++) begin
      bus.wr_en[p]             = s_we[p];
      bus.wr_addr[p*AW +: AW]  = AW'(s_wa[p]);
      bus.wr_data[p*DW +: DW]  = s_wd[p];
    end
    for (int r = 0; r < NR; r++) begin
      bus.rd_en[r]             = s_re[r];
      bus.rd_addr[r*AW +: AW]  = AW'(s_ra[r]);
    end
    for (int r = 0; r < NR; r++) begin
      if (s_re[r]) begin
        exp_dat[r] = mem[s_ra[r]];
`ifdef LVT_BYPASS_EN
        for (int p = 0; p < NW; p++)
          if (s_we[p] && s_wa[p] == s_ra[r]) exp_dat[r] = s_wd[p];
`endif
      end
    end
    exp_vld = s_re;
    for (int p = 0; p < NW; p++)
      if (s_we[p]) mem[s_wa[p]] = s_wd[p];
    @(posedge clk);
    #1;
    s_we = '0;
    s_re = '0;
    bus.wr_en = '0;
    bus.rd_en = '0;
  endtask

  task automatic release_and_wait(output int cnt);
    rst = 1'b0;
    cnt = 0;
    while (cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.ready === 1'b1) break;
    end
    model_reset();
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
    total++; if (bus.rd_valid !== '0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rd_valid); end
    total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.rd_data); end
    release_and_wait(cnt);
    total++; if (cnt !== DEPTH) begin bad++; $display("FAIL ready_latency got=%0d want=%0d", cnt, DEPTH); end
    s_re = 2'b11; s_ra[0] = 5; s_ra[1] = 5;
    tick();
    for (int r = 0; r < NR; r++) begin
      total++;
      if (bus.rd_valid[r] !== 1'b1 || bus.rd_data[r*DW +: DW] !== 32'd0) begin
        bad++; $display("FAIL cleared_read%0d got v=%b d=%h want v=1 d=0", r, bus.rd_valid[r], bus.rd_data[r*DW +: DW]);
      end
    end
  endtask

  task automatic test_basic_write();
    s_we[0] = 1'b1; s_wa[0] = 10; s_wd[0] = 32'd5;
    tick();
    total++; if (bus.rd_valid !== '0) begin bad++; $display("FAIL idle_valid got=%b want=0", bus.rd_valid); end
    s_re[0] = 1'b1; s_ra[0] = 10;
    tick();
    total++;
    if (bus.rd_valid[0] !== 1'b1 || bus.rd_data[0 +: DW] !== 32'd5) begin
      bad++; $display("FAIL basic_read got v=%b d=%0d want v=1 d=5", bus.rd_valid[0], bus.rd_data[0 +: DW]);
    end
    tick();
    total++;
    if (bus.rd_valid[0] !== 1'b0 || bus.rd_data[0 +: DW] !== 32'd5) begin
      bad++; $display("FAIL hold_read got v=%b d=%0d want v=0 d=5", bus.rd_valid[0], bus.rd_data[0 +: DW]);
    end
  endtask

  task automatic test_collision();
    s_we = 3'b011; s_wa[0] = 50; s_wd[0] = 32'd25; s_wa[1] = 50; s_wd[1] = 32'd30;
    tick();
    s_we = 3'b111; s_wa[0] = 51; s_wd[0] = 32'd1; s_wa[1] = 51; s_wd[1] = 32'd2; s_wa[2] = 51; s_wd[2] = 32'd3;
    tick();
    s_re = 2'b11; s_ra[0] = 50; s_ra[1] = 51;
    tick();
    total++; if (bus.rd_data[0 +: DW] !== 32'd30) begin bad++; $display("FAIL collide2 got=%0d want=30", bus.rd_data[0 +: DW]); end
    total++; if (bus.rd_data[DW +: DW] !== 32'd3) begin bad++; $display("FAIL collide3 got=%0d want=3", bus.rd_data[DW +: DW]); end
  endtask

  task automatic test_overwrite();
    s_we[0] = 1'b1; s_wa[0] = 90; s_wd[0] = 32'd45;
    tick();
    tick();
    s_we[1] = 1'b1; s_wa[1] = 90; s_wd[1] = 32'd50;
    tick();
    s_re = 2'b11; s_ra[0] = 90; s_ra[1] = 95;
    tick();
    total++; if (bus.rd_data[0 +: DW] !== 32'd50) begin bad++; $display("FAIL overwrite got=%0d want=50", bus.rd_data[0 +: DW]); end
    total++; if (bus.rd_data[DW +: DW] !== 32'd0) begin bad++; $display("FAIL unwritten got=%0d want=0", bus.rd_data[DW +: DW]); end
  endtask

  task automatic test_read_during_write();
    logic [DW-1:0] want;
`ifdef LVT_BYPASS_EN
    want = 32'd7;
`else
    want = 32'd0;
`endif
    s_we[0] = 1'b1; s_wa[0] = 3; s_wd[0] = 32'd7;
    s_re[1] = 1'b1; s_ra[1] = 3;
    tick();
    total++; if (bus.rd_data[DW +: DW] !== want) begin bad++; $display("FAIL rdw got=%0d want=%0d", bus.rd_data[DW +: DW], want); end
    s_re[1] = 1'b1; s_ra[1] = 3;
    tick();
    total++; if (bus.rd_data[DW +: DW] !== 32'd7) begin bad++; $display("FAIL rdw_after got=%0d want=7", bus.rd_data[DW +: DW]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NW; p++) begin
        s_we[p] = ($urandom_range(0, 2) != 0);
        s_wa[p] = (i % 4 == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
        s_wd[p] = $urandom;
      end
      for (int r = 0; r < NR; r++) begin
        s_re[r] = ($urandom_range(0, 3) != 0);
        s_ra[r] = (i % 4 == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
      end
      tick();
      for (int r = 0; r < NR; r++) begin
        total++;
        if (bus.rd_valid[r] !== exp_vld[r] || bus.rd_data[r*DW +: DW] !== exp_dat[r]) begin
          bad++;
          $display("FAIL random_c%0d_p%0d got v=%b d=%h want v=%b d=%h", i, r,
                   bus.rd_valid[r], bus.rd_data[r*DW +: DW], exp_vld[r], exp_dat[r]);
        end
      end
    end
  endtask

  task automatic test_restart();
    int cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL midclear_ready got=%b want=0", bus.ready); end
    release_and_wait(cnt);
    total++; if (cnt !== DEPTH) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", cnt, DEPTH); end
    s_we[2] = 1'b1; s_wa[2] = 1; s_wd[2] = 32'd99;
    tick();
    s_re[0] = 1'b1; s_ra[0] = 1;
    tick();
    total++; if (bus.rd_data[0 +: DW] !== 32'd99) begin bad++; $display("FAIL pre_reset got=%0d want=99", bus.rd_data[0 +: DW]); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.ready !== 1'b0 || bus.rd_valid !== '0 || bus.rd_data !== '0) begin
      bad++; $display("FAIL midrun_reset got r=%b v=%b d=%h want all 0", bus.ready, bus.rd_valid, bus.rd_data);
    end
    release_and_wait(cnt);
    total++; if (cnt !== DEPTH) begin bad++; $display("FAIL rerun_latency got=%0d want=%0d", cnt, DEPTH); end
    s_re[0] = 1'b1; s_ra[0] = 1;
    tick();
    total++; if (bus.rd_data[0 +: DW] !== 32'd0 || bus.rd_valid[0] !== 1'b1) begin
      bad++; $display("FAIL post_reset got v=%b d=%0d want v=1 d=0", bus.rd_valid[0], bus.rd_data[0 +: DW]);
    end
  endtask

  initial begin
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = '0; bus.rd_addr = '0;
    model_reset();
    test_reset();
    test_basic_write();
    test_collision();
    test_overwrite();
    test_read_during_write();
    test_random();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
